jk_ff_bank: RTL

JK_FF_BANK -- requirements
Module: jk_ff_bank

---
 rtl/jk_pkg.sv | 39 +++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_ff_bank.sv | 93 +++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: JK operation encoding and next-state helper shared by the JK flip-flop bank.
`default_nettype none

package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_SET  = 2'b01,
    JK_CLR  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_t;

  function automatic jk_op_t jk_decode(input logic j, input logic k);
    jk_op_t op;
    op = JK_HOLD;
    case ({j, k})
      2'b10:   op = JK_SET;
      2'b01:   op = JK_CLR;
      2'b11:   op = JK_TOG;
      default: op = JK_HOLD;
    endcase
    return op;
  endfunction

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    nq = q;
    case (jk_decode(j, k))
      JK_SET:  nq = 1'b1;
      JK_CLR:  nq = 1'b0;
      JK_TOG:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop channel with parallel load (load > en > hold), async active-low reset.
`default_nettype none

module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH independent JK channels with change pulse; define JK_BANK_TCNT_EN
// to add the saturating toggle-event counter output tcnt.
`default_nettype none

module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             chg
`ifdef JK_BANK_TCNT_EN
  ,
  output logic [CNT_W-1:0] tcnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("jk_ff_bank: WIDTH must be in 1..64");
  end

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("jk_ff_bank: CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] w_q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .j    (j[i]),
      .k    (k[i]),
      .load (load),
      .d    (d[i]),
      .q    (q[i])
    );
  end

  assign q_n = ~q;

  // Mirror of the cells' next state, used only to detect that an edge will change q.
  always_comb begin
    w_q_next = q;
    if (load) begin
      w_q_next = d;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_q_next[i] = jk_next(q[i], j[i], k[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chg <= 1'b0;
    end else begin
      chg <= (w_q_next != q);
    end
  end

`ifdef JK_BANK_TCNT_EN
  localparam logic [CNT_W-1:0] TCNT_MAX = '1;

  logic w_tog_event;

  assign w_tog_event = !load && en && (|(j & k));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (w_tog_event && (tcnt != TCNT_MAX)) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
